// File: rtl/gate_response_checker.sv
// Response checker for an N-input logic gate: sweeps all 2^N input vectors,
// compares the gate output against FUNC and records mismatches.
module gate_response_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int FUNC   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dut_out,
    output logic [N-1:0] stim,
    output logic         expected,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         mismatch,
    output logic [N:0]   err_count,
    output logic         fail_valid,
    output logic [N-1:0] first_fail
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] settle_cnt;
    logic          last_vec;

    assign last_vec = (stim == '1);

    always_comb begin
        expected = ~&stim;
        case (FUNC)
            1:       expected = ~|stim;
            2:       expected = &stim;
            3:       expected = |stim;
            4:       expected = ^stim;
            5:       expected = ~^stim;
            default: expected = ~&stim;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (settle_cnt == '0) state_next = SAMPLE;
            SAMPLE:  state_next = last_vec ? DONE : DRIVE;
            DONE:    if (start) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE) || (state == SAMPLE);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim       <= '0;
            settle_cnt <= '0;
            mismatch   <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stim       <= '0;
                        settle_cnt <= RELOAD;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    if (dut_out != expected) begin
                        err_count <= err_count + 1'b1;
                        mismatch  <= 1'b1;
                        if (!fail_valid) begin
                            first_fail <= stim;
                            fail_valid <= 1'b1;
                        end
                    end
                    // stim freezes on the final vector so DONE reports it
                    if (!last_vec) begin
                        stim       <= stim + 1'b1;
                        settle_cnt <= RELOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response end for the team's basic logic-gate blocks; it is the counterpart of the stimulus testbenches.
- On `start`, it sweeps every input combination of an N-input gate under test and holds each combination for a settle window.
- It samples the gate's output, compares it against the expected function, and counts mismatches.
- It reports done, pass and the first failing vector.
- It sits beside a gate instance (e.g. the NAND gate) in hardware self-test wrappers and in simulation.

Parameters:
- N, 2: number of gate inputs (1..8); sweep covers 2^N vectors.
- SETTLE, 1: cycles each vector is held before sampling (>=1).
- FUNC, 0: expected function. 0=NAND, 1=NOR, 2=AND, 3=OR, 4=XOR, 5=XNOR. Other values behave as NAND.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- dut_out  input  1  output of the gate under test.
- stim  output  N  input vector driven to the gate under test.
- expected  output  1  FUNC applied to the current stim (combinational from stim).
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count==0.
- mismatch  output  1  one-cycle registered pulse for each failed comparison.
- err_count  output  N+1  number of failed vectors in the current or last sweep.
- fail_valid  output  1  at least one failure recorded.
- first_fail  output  N  stim value of the first failing vector.

Behaviour:
- Reset: rst_n==0 at a rising edge forces the following state regardless of current state (mid-sweep included):
  - state=IDLE, stim=0, settle counter=0
  - busy=0, done=0, pass=0, mismatch=0
  - err_count=0, fail_valid=0, first_fail=0
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: outputs at reset values. start==1 at an edge -> DRIVE, and the same edge does the following:
  - stim=0
  - settle counter=SETTLE-1
  - err_count=0, fail_valid=0, first_fail=0
- DRIVE: stim held. If counter!=0, decrement and stay. If counter==0 -> SAMPLE.
- SAMPLE: lasts exactly one cycle; comparison is dut_out vs expected, taken at the edge ending SAMPLE. On mismatch at that edge:
  - err_count+1
  - mismatch=1 for the next cycle only
  - if fail_valid==0: first_fail=stim, fail_valid=1
- Transition out of SAMPLE:
  - If stim==all ones -> DONE; stim holds its last value.
  - Else stim+1, counter=SETTLE-1 -> DRIVE.
- DONE: done=1 and pass=(err_count==0). stim, err_count and first_fail are held. start==1 -> restart exactly as from IDLE; done drops on that edge.
- start is ignored in DRIVE and SAMPLE.
- Sweep length: 2^N*(SETTLE+1) cycles from the start edge until done rises. Example: N=2, SETTLE=1 gives 8 cycles.
- err_count cannot overflow: its maximum is 2^N, which fits in N+1 bits.
- mismatch is 0 in all cycles except the one following a failed SAMPLE edge.
- expected is computed over all N bits of stim:
  - NAND=~&stim, NOR=~|stim
  - AND=&stim, OR=|stim
  - XOR=^stim, XNOR=~^stim
- dut_out is sampled only at the SAMPLE edge; its value at any other time is ignored.

Test Plan:
- Correct NAND: N=2, SETTLE=1, FUNC=0, checker wired to a NAND gate, pulse start.
  - stim steps 00,01,10,11, each held 2 cycles.
  - done rises 8 cycles after start; pass=1, err_count=0, fail_valid=0, mismatch never high.
- Stuck-at-0 output: same configuration with dut_out tied 0.
  - Vectors 00,01,10 fail (NAND=1 for each).
  - err_count=3, first_fail=00, pass=0, three mismatch pulses.
- Single bad vector: dut_out = NAND except forced 1 when stim=11.
  - err_count=1, first_fail=11, fail_valid=1, mismatch one cycle after the stim=11 SAMPLE edge.
- Settle window and start gating: N=3, SETTLE=3, FUNC=2 against a correct AND gate; pulse start again mid-sweep.
  - Each vector held 4 cycles; done rises 32 cycles after the first start; the second start is ignored.
  - pass=1.
- Reset and restart: assert rst_n=0 for one edge during vector 10.
  - All outputs return to reset values; state is IDLE.
  - Then start from DONE after a failing sweep: err_count, fail_valid and first_fail clear on the start edge, and the sweep reruns from stim=00.
